window_seq_ctrl: RTL and testbench

Sequencer for the bit-serial 3-row line-buffer window used by the BNN conv stage. It accepts a frame of binarised pixels from an upstream valid/ready source, drives the window's shift enable, data bit and row-width select, and tracks row/column position. It flags when the window's 3-bit vertical tap column is valid, and when a full 3x3 window (the last three columns) is valid, tagged with output coordinates. Layer 0 uses 28-pixel rows (window state 0); layer 1 uses 26-pixel rows (window state 1).

---
 rtl/bnn_pkg.sv | 17 +
 rtl/window_seq_ctrl_pos_counter.sv | 39 +++
 rtl/window_seq_ctrl.sv | 109 ++++++++++
 tb/tb_window_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and encodings for the BNN conv-stage window sequencer.
package bnn_pkg;

   localparam int CW     = 5;
   localparam int IMG_W0 = 28;
   localparam int IMG_W1 = 26;

   localparam logic WIN_ST_L0 = 1'b0;
   localparam logic WIN_ST_L1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/window_seq_ctrl_pos_counter.sv
// Row/column position counter that wraps at a runtime row width.
module win_pos_counter #(
   parameter int CW = bnn_pkg::CW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] width,
   output logic [CW-1:0] col,
   output logic [CW-1:0] row,
   output logic          last
);

   logic col_end;
   logic row_end;

   assign col_end = (col == width - CW'(1));
   assign row_end = (row == width - CW'(1));
   assign last    = col_end && row_end;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + CW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/window_seq_ctrl.sv
// Frame sequencer for the bit-serial 3-row line-buffer window: handshake,
// position tracking and registered column/window valid pulses.
module window_seq_ctrl #(
   parameter int W0 = bnn_pkg::IMG_W0,
   parameter int W1 = bnn_pkg::IMG_W1,
   parameter int CW = bnn_pkg::CW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          frame_start,
   input  logic          layer_sel,
   input  logic          abort,
   input  logic          in_valid,
   input  logic          in_bit,
   output logic          in_ready,
   input  logic          out_ready,
   output logic          win_shift,
   output logic          win_din,
   output logic          win_state,
   output logic          col_valid,
   output logic          win_valid,
   output logic [CW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          busy,
   output logic          frame_done
);

   import bnn_pkg::*;

   seq_state_t    state;
   seq_state_t    state_nxt;
   logic          start;
   logic          accept;
   logic          pos_last;
   logic [CW-1:0] width;
   logic [CW-1:0] row;
   logic [CW-1:0] col;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Abort wins over acceptance, so the RUN exit on abort is checked first.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (frame_start) begin
               state_nxt = RUN;
               start     = 1'b1;
            end
         end
         RUN: begin
            if (abort)                    state_nxt = IDLE;
            else if (accept && pos_last)  state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready drops during abort so upstream never sees a pixel as taken.
   assign in_ready   = (state == RUN) && out_ready && !abort;
   assign accept     = in_valid && in_ready;
   assign win_shift  = accept;
   assign win_din    = in_bit;
   assign busy       = (state == RUN);
   assign frame_done = (state == DONE);

   assign width = (win_state == WIN_ST_L1) ? CW'(W1) : CW'(W0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      win_state <= WIN_ST_L0;
      else if (start) win_state <= layer_sel;
   end

   win_pos_counter #(
      .CW (CW)
   ) u_pos (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (start),
      .en    (accept),
      .width (width),
      .col   (col),
      .row   (row),
      .last  (pos_last)
   );

   // Pulses describe the pixel accepted on the previous edge and are never stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col_valid <= 1'b0;
         win_valid <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
      end else begin
         col_valid <= accept && (row >= CW'(2));
         win_valid <= accept && (row >= CW'(2)) && (col >= CW'(2));
         if (accept && (row >= CW'(2)) && (col >= CW'(2))) begin
            out_row <= row - CW'(2);
            out_col <= col - CW'(2);
         end
      end
   end

endmodule

// File: tb/tb_window_seq_ctrl.sv
// Randomized bench for window_seq_ctrl against a pixel-index reference model.
module tb_window_seq_ctrl;

   localparam int CW = 5;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          frame_start = 1'b0;
   logic          layer_sel = 1'b0;
   logic          abort = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_bit = 1'b0;
   logic          in_ready;
   logic          out_ready = 1'b0;
   logic          win_shift;
   logic          win_din;
   logic          win_state;
   logic          col_valid;
   logic          win_valid;
   logic [CW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic          busy;
   logic          frame_done;

   window_seq_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .frame_start (frame_start),
      .layer_sel   (layer_sel),
      .abort       (abort),
      .in_valid    (in_valid),
      .in_bit      (in_bit),
      .in_ready    (in_ready),
      .out_ready   (out_ready),
      .win_shift   (win_shift),
      .win_din     (win_din),
      .win_state   (win_state),
      .col_valid   (col_valid),
      .win_valid   (win_valid),
      .out_row     (out_row),
      .out_col     (out_col),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: frame-level view by accepted-pixel index.
   int   m_st = M_IDLE;
   logic m_ws = 1'b0;
   int   m_w = 28;
   int   m_k = 0;
   logic pend_col = 1'b0;
   logic pend_win = 1'b0;
   logic [2*CW-1:0] exp_q[$];
   logic got_bits[1024];
   int   n_sh, n_col, n_win;
   int   first_r, first_c, last_r, last_c;
   int   done_cnt = 0;
   bit   done_seen = 0;
   bit   ckb_mode = 0;

   always @(negedge clk) begin
      logic exp_rdy;
      int r, c, idx;
      logic [8:0] tap, ref9;
      logic [2*CW-1:0] e;
      if (!rstn) begin
         m_st = M_IDLE;
         m_ws = 1'b0;
         pend_col = 1'b0;
         pend_win = 1'b0;
         exp_q.delete();
      end else begin
         exp_rdy = (m_st == M_RUN) && out_ready && !abort;
         check("in_ready", in_ready, exp_rdy);
         check("win_shift", win_shift, in_valid && exp_rdy);
         check("busy", busy, m_st == M_RUN);
         check("frame_done", frame_done, m_st == M_DONE);
         check("win_state", win_state, m_ws);
         check("col_valid", col_valid, pend_col);
         check("win_valid", win_valid, pend_win);
         if (win_shift) begin
            check("win_din", win_din, in_bit);
            n_sh++;
            if (m_k < 1024) got_bits[m_k] = win_din;
         end
         if (col_valid) n_col++;
         if (win_valid) begin
            if (exp_q.size() == 0) begin
               check("win_extra", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_row", out_row, e[2*CW-1:CW]);
               check("out_col", out_col, e[CW-1:0]);
            end
            if (n_win == 0) begin
               first_r = out_row;
               first_c = out_col;
            end
            last_r = out_row;
            last_c = out_col;
            n_win++;
            if (ckb_mode && int'(out_row) <= m_w - 3 && int'(out_col) <= m_w - 3) begin
               for (int i = 0; i < 3; i++) begin
                  for (int j = 0; j < 3; j++) begin
                     idx = (int'(out_row) + i) * m_w + int'(out_col) + j;
                     tap[i*3+j]  = got_bits[idx];
                     ref9[i*3+j] = ((int'(out_row) + i + int'(out_col) + j) % 2) == 1;
                  end
               end
               check("tap3x3", tap, ref9);
            end
         end
         if (m_st == M_DONE) begin
            check("frame_shifts", n_sh, m_w * m_w);
            check("frame_cols", n_col, m_w * (m_w - 2));
            check("frame_wins", n_win, (m_w - 2) * (m_w - 2));
            check("first_row", first_r, 0);
            check("first_col", first_c, 0);
            check("last_row", last_r, m_w - 3);
            check("last_col", last_c, m_w - 3);
            done_seen = 1;
            done_cnt++;
         end
         pend_col = 1'b0;
         pend_win = 1'b0;
         case (m_st)
            M_IDLE: begin
               if (frame_start) begin
                  m_st = M_RUN;
                  m_ws = layer_sel;
                  m_w = layer_sel ? 26 : 28;
                  m_k = 0;
                  n_sh = 0;
                  n_col = 0;
                  n_win = 0;
                  done_seen = 0;
               end
            end
            M_RUN: begin
               if (abort) begin
                  m_st = M_IDLE;
               end else if (in_valid && out_ready) begin
                  r = m_k / m_w;
                  c = m_k % m_w;
                  pend_col = (r >= 2);
                  pend_win = (r >= 2) && (c >= 2);
                  if (pend_win) exp_q.push_back({CW'(r - 2), CW'(c - 2)});
                  m_k++;
                  if (m_k == m_w * m_w) m_st = M_DONE;
               end
            end
            default: m_st = M_IDLE;
         endcase
      end
   end

   task automatic reset_checks(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_win_shift"}, win_shift, 0);
      check({tag, "_col_valid"}, col_valid, 0);
      check({tag, "_win_valid"}, win_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_out_row"}, out_row, 0);
      check({tag, "_out_col"}, out_col, 0);
      check({tag, "_win_state"}, win_state, 0);
   endtask

   task automatic run_frame(input logic sel, input int pv, input int pr, input bit ckb,
                            input int abort_at, input int fs_at, input int rst_at);
      int cyc = 0;
      bit stop = 0;
      int w = sel ? 26 : 28;
      int done_before = done_cnt;
      ckb_mode = ckb;
      @(posedge clk); #1;
      frame_start = 1'b1;
      layer_sel = sel;
      in_valid = 1'b0;
      @(posedge clk); #1;
      while (!stop) begin
         frame_start = 1'b0;
         abort = 1'b0;
         in_valid = ($urandom_range(0, 99) < pv);
         out_ready = ($urandom_range(0, 99) < pr);
         in_bit = ckb ? (((m_k / w + m_k % w) % 2) == 1) : 1'($urandom_range(0, 1));
         if (m_k == fs_at) begin
            frame_start = 1'b1;
            layer_sel = ~sel;
         end
         if (m_k == abort_at) begin
            abort = 1'b1;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            in_valid = 1'b0;
            check("abort_idle", busy, 0);
            repeat (2) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt, done_before);
            stop = 1;
         end else if (m_k == rst_at) begin
            rstn = 1'b0;
            #1;
            reset_checks("midrst");
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            rstn = 1'b1;
            stop = 1;
         end else begin
            @(posedge clk); #1;
            cyc++;
            if (done_seen) begin
               stop = 1;
            end else if (cyc > 20000) begin
               check("frame_timeout", cyc, 0);
               stop = 1;
            end
         end
      end
      frame_start = 1'b0;
      abort = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      #12;
      reset_checks("rst");
      @(posedge clk); #1;
      rstn = 1'b1;
      run_frame(1'b0, 100, 100, 0, -1, -1, -1);
      run_frame(1'b1, 100, 100, 1, -1, -1, -1);
      run_frame(1'b0, 50, 70, 0, -1, -1, -1);
      run_frame(1'b0, 100, 100, 0, 100, -1, -1);
      run_frame(1'b1, 100, 100, 0, -1, -1, -1);
      run_frame(1'b1, 100, 100, 0, -1, 50, -1);
      run_frame(1'b0, 100, 100, 0, -1, -1, 400);
      run_frame(1'b1, 50, 70, 1, -1, -1, -1);
      repeat (3) @(posedge clk);
      #1;
      check("frames_done", done_cnt, 6);
      check("exp_q_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
